// File: rtl/gbe_rx_cpu_ctrl_pkg.sv
// gbe_rx_cpu_ctrl_pkg
// Purpose: shared constants for the CPU receive-path sequencer. Holds the
//          register word addresses, the CTRL/STATUS bit positions and the
//          FSM state encoding.
// Ports:   none (package).
package gbe_rx_cpu_ctrl_pkg;

  localparam logic [1:0] ADDR_STATUS  = 2'd0;
  localparam logic [1:0] ADDR_CTRL    = 2'd1;
  localparam logic [1:0] ADDR_COUNT   = 2'd2;
  localparam logic [1:0] ADDR_TIMEOUT = 2'd3;

  localparam int CTRL_ENABLE_BIT    = 0;
  localparam int CTRL_AUTO_BIT      = 1;
  localparam int CTRL_RELEASE_BIT   = 8;

  localparam int STATUS_SIZE_MSB    = 10;
  localparam int STATUS_SEL_BIT     = 16;
  localparam int STATUS_PENDING_BIT = 31;

  // state   | meaning
  // IDLE    | waiting for an enabled capture of rx_cpu_ready
  // PENDING | descriptor latched, irq high, waiting for release/timeout
  // ACK     | rx_cpu_ack high until rx_cpu_ready is seen low
  // CLEAR   | one cycle with ready and ack both low before re-arming
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PENDING = 2'd1,
    ST_ACK     = 2'd2,
    ST_CLEAR   = 2'd3
  } state_e;

endpackage

// File: rtl/gbe_rx_cpu_ctrl_sat_counter.sv
// gbe_sat_counter
// Purpose: saturating event counter. A clear coinciding with an increment
//          leaves the counter at 1 so that event is not lost.
// Ports:
//   clk_i   clock
//   rst_i   synchronous active-high reset
//   clr_i   clear strobe
//   inc_i   increment strobe
//   cnt_o   current count
module gbe_sat_counter #(
  parameter int W = 16
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         clr_i,
  input  logic         inc_i,
  output logic [W-1:0] cnt_o
);

  localparam logic [W-1:0] ONE = {{(W-1){1'b0}}, 1'b1};

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = inc_i ? ONE : '0;
    end else if (inc_i && (cnt_q != '1)) begin
      cnt_d = cnt_q + ONE;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/gbe_rx_cpu_ctrl.sv
// gbe_rx_cpu_ctrl
// Purpose: runs the receiver's CPU ping-pong handshake for software. Latches
//          a frame descriptor, raises irq while it is pending, and acks the
//          frame on a RELEASE write or after a programmable timeout.
// Ports:
//   mac_clk            clock
//   mac_rst            synchronous active-high reset
//   rx_cpu_ready       frame-ready flag from the receiver
//   rx_cpu_size        frame byte count
//   rx_cpu_buffer_sel  buffer holding the frame
//   rx_cpu_ack         acknowledge to the receiver (registered)
//   reg_addr/reg_wr/reg_wr_data/reg_rd   CPU register bus
//   reg_rd_data        registered read data, held until the next read
//   irq                level interrupt while a frame is pending
module gbe_rx_cpu_ctrl
  import gbe_rx_cpu_ctrl_pkg::*;
#(
  parameter logic [23:0] TIMEOUT_DEFAULT = 24'd12500000,
  parameter int          CNT_W           = 16
) (
  input  logic        mac_clk,
  input  logic        mac_rst,
  input  logic        rx_cpu_ready,
  input  logic [10:0] rx_cpu_size,
  input  logic        rx_cpu_buffer_sel,
  output logic        rx_cpu_ack,
  input  logic [1:0]  reg_addr,
  input  logic        reg_wr,
  input  logic [31:0] reg_wr_data,
  input  logic        reg_rd,
  output logic [31:0] reg_rd_data,
  output logic        irq
);

  state_e      state_q;
  logic        ack_q, irq_q;
  logic [23:0] timer_q;
  logic [10:0] size_q;
  logic        sel_q;
  logic        enable_q, auto_q;
  logic [23:0] timeout_q;
  logic [31:0] rd_data_q, rd_data_d;
  logic [CNT_W-1:0] acc_cnt, drop_cnt;

  logic        release_req, capture, timeout_hit, count_clr;
  logic [23:0] timeout_eff;

  assign release_req = reg_wr && (reg_addr == ADDR_CTRL) && reg_wr_data[CTRL_RELEASE_BIT];
  assign count_clr   = reg_wr && (reg_addr == ADDR_COUNT);
  assign capture     = (state_q == ST_IDLE) && enable_q && rx_cpu_ready;
  // A zero timeout is treated as one cycle.
  assign timeout_eff = (timeout_q == 24'd0) ? 24'd1 : timeout_q;
  // ">=" rather than "==" so a TIMEOUT lowered below the running timer still fires.
  assign timeout_hit = (state_q == ST_PENDING) && auto_q && !release_req &&
                       (timer_q >= (timeout_eff - 24'd1));

  always_ff @(posedge mac_clk) begin
    if (mac_rst) begin
      state_q <= ST_IDLE;
      ack_q   <= 1'b0;
      irq_q   <= 1'b0;
      timer_q <= '0;
      size_q  <= '0;
      sel_q   <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (capture) begin
            size_q  <= rx_cpu_size;
            sel_q   <= rx_cpu_buffer_sel;
            timer_q <= '0;
            irq_q   <= 1'b1;
            state_q <= ST_PENDING;
          end
        end
        ST_PENDING: begin
          if (release_req || timeout_hit) begin
            irq_q   <= 1'b0;
            ack_q   <= 1'b1;
            state_q <= ST_ACK;
          end else if (timer_q != '1) begin
            timer_q <= timer_q + 24'd1;
          end
        end
        ST_ACK: begin
          if (!rx_cpu_ready) begin
            ack_q   <= 1'b0;
            state_q <= ST_CLEAR;
          end
        end
        ST_CLEAR: state_q <= ST_IDLE;
        default: begin
          ack_q   <= 1'b0;
          irq_q   <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  gbe_sat_counter #(.W(CNT_W)) u_acc_cnt (
    .clk_i (mac_clk),
    .rst_i (mac_rst),
    .clr_i (count_clr),
    .inc_i (capture),
    .cnt_o (acc_cnt)
  );

  gbe_sat_counter #(.W(CNT_W)) u_drop_cnt (
    .clk_i (mac_clk),
    .rst_i (mac_rst),
    .clr_i (count_clr),
    .inc_i (timeout_hit),
    .cnt_o (drop_cnt)
  );

  // Read mux uses current register values, so a same-cycle write reads old data.
  always_comb begin
    rd_data_d = '0;
    case (reg_addr)
      ADDR_STATUS: begin
        rd_data_d[STATUS_SIZE_MSB:0]  = size_q;
        rd_data_d[STATUS_SEL_BIT]     = sel_q;
        rd_data_d[STATUS_PENDING_BIT] = (state_q == ST_PENDING);
      end
      ADDR_CTRL: begin
        rd_data_d[CTRL_ENABLE_BIT] = enable_q;
        rd_data_d[CTRL_AUTO_BIT]   = auto_q;
      end
      ADDR_COUNT:   rd_data_d = {16'(drop_cnt), 16'(acc_cnt)};
      ADDR_TIMEOUT: rd_data_d = {8'd0, timeout_q};
      default:      rd_data_d = '0;
    endcase
  end

  always_ff @(posedge mac_clk) begin
    if (mac_rst) begin
      enable_q  <= 1'b0;
      auto_q    <= 1'b0;
      timeout_q <= TIMEOUT_DEFAULT;
      rd_data_q <= '0;
    end else begin
      if (reg_wr && (reg_addr == ADDR_CTRL)) begin
        enable_q <= reg_wr_data[CTRL_ENABLE_BIT];
        auto_q   <= reg_wr_data[CTRL_AUTO_BIT];
      end
      if (reg_wr && (reg_addr == ADDR_TIMEOUT)) begin
        timeout_q <= reg_wr_data[23:0];
      end
      if (reg_rd) begin
        rd_data_q <= rd_data_d;
      end
    end
  end

  assign rx_cpu_ack  = ack_q;
  assign irq         = irq_q;
  assign reg_rd_data = rd_data_q;

endmodule

// File: tb/tb_gbe_rx_cpu_ctrl.sv
module tb_gbe_rx_cpu_ctrl;

  localparam logic [1:0] A_STATUS = 2'd0, A_CTRL = 2'd1, A_COUNT = 2'd2, A_TIMEOUT = 2'd3;

  logic        mac_clk = 1'b0;
  logic        mac_rst = 1'b1;
  logic        rx_cpu_ready = 1'b0;
  logic [10:0] rx_cpu_size = '0;
  logic        rx_cpu_buffer_sel = 1'b0;
  logic        rx_cpu_ack;
  logic [1:0]  reg_addr = '0;
  logic        reg_wr = 1'b0;
  logic [31:0] reg_wr_data = '0;
  logic        reg_rd = 1'b0;
  logic [31:0] reg_rd_data;
  logic        irq;

  int n_cmp = 0;
  int n_fail = 0;
  int m_acc = 0;
  int m_drop = 0;

  always #4 mac_clk = ~mac_clk;

  gbe_rx_cpu_ctrl #(.TIMEOUT_DEFAULT(24'd12500000), .CNT_W(16)) dut (
    .mac_clk           (mac_clk),
    .mac_rst           (mac_rst),
    .rx_cpu_ready      (rx_cpu_ready),
    .rx_cpu_size       (rx_cpu_size),
    .rx_cpu_buffer_sel (rx_cpu_buffer_sel),
    .rx_cpu_ack        (rx_cpu_ack),
    .reg_addr          (reg_addr),
    .reg_wr            (reg_wr),
    .reg_wr_data       (reg_wr_data),
    .reg_rd            (reg_rd),
    .reg_rd_data       (reg_rd_data),
    .irq               (irq)
  );

  task automatic step();
    @(posedge mac_clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    reg_addr = a; reg_wr_data = d; reg_wr = 1'b1;
    step();
    reg_wr = 1'b0;
  endtask

  task automatic rd_check(input string tag, input logic [1:0] a, input logic [31:0] exp);
    reg_addr = a; reg_rd = 1'b1;
    step();
    reg_rd = 1'b0;
    check(tag, reg_rd_data, exp);
  endtask

  function automatic int sat(input int x);
    return (x > 65535) ? 65535 : x;
  endfunction

  function automatic logic [31:0] exp_count();
    logic [31:0] v;
    v = (32'(sat(m_drop)) << 16) | 32'(sat(m_acc));
    return v;
  endfunction

  function automatic logic [31:0] exp_status(input bit pend, input bit sel, input int size);
    logic [31:0] v;
    v = (pend ? 32'h8000_0000 : 32'h0) | (sel ? 32'h0001_0000 : 32'h0) | 32'(size & 11'h7FF);
    return v;
  endfunction

  // Receiver present a frame; capture (if armed) happens at the next edge.
  task automatic present(input int size, input bit sel);
    rx_cpu_size = 11'(size); rx_cpu_buffer_sel = sel; rx_cpu_ready = 1'b1;
    step();
  endtask

  // Receiver drops ready after seeing ack; ack must fall, then the FSM re-arms.
  task automatic handshake(input string tag);
    rx_cpu_ready = 1'b0;
    step();
    check({tag, "_ack_low"}, 32'(rx_cpu_ack), 32'd0);
    step();
  endtask

  initial begin
    int k, size, T, d, L;
    bit sel, saw;

    // ---------------- reset state ----------------
    step(); step();
    check("rst_ack", 32'(rx_cpu_ack), 32'd0);
    check("rst_irq", 32'(irq), 32'd0);
    check("rst_rd", reg_rd_data, 32'd0);
    mac_rst = 1'b0;
    rd_check("rst_status", A_STATUS, 32'd0);
    rd_check("rst_ctrl", A_CTRL, 32'd0);
    rd_check("rst_count", A_COUNT, 32'd0);
    rd_check("rst_timeout", A_TIMEOUT, 32'd12500000);

    // ---------------- disabled: no capture ----------------
    size = int'($urandom_range(1, 2047));
    rx_cpu_size = 11'(size); rx_cpu_buffer_sel = 1'b1; rx_cpu_ready = 1'b1;
    saw = 1'b0;
    for (int i = 0; i < 100; i++) begin
      step();
      if (irq || rx_cpu_ack) saw = 1'b1;
    end
    check("dis_no_irq_ack", 32'(saw), 32'd0);
    rd_check("dis_count", A_COUNT, 32'd0);
    wr(A_CTRL, 32'h1);
    check("en_same_edge_irq", 32'(irq), 32'd0);
    step();
    m_acc++;
    check("en_capture_irq", 32'(irq), 32'd1);
    rd_check("en_status", A_STATUS, exp_status(1'b1, 1'b1, size));
    wr(A_CTRL, 32'h101);
    check("en_rel_ack", 32'(rx_cpu_ack), 32'd1);
    check("en_rel_irq", 32'(irq), 32'd0);
    handshake("en");
    rd_check("en_count", A_COUNT, exp_count());

    // ---------------- frame of 64 on buffer 0 ----------------
    wr(A_COUNT, 32'h0); m_acc = 0; m_drop = 0;
    present(64, 1'b0); m_acc++;
    check("f64_irq", 32'(irq), 32'd1);
    rd_check("f64_status", A_STATUS, 32'h8000_0040);
    wr(A_CTRL, 32'h101);
    check("f64_ack", 32'(rx_cpu_ack), 32'd1);
    handshake("f64");
    rd_check("f64_count", A_COUNT, 32'h0000_0001);

    // ---------------- auto release, TIMEOUT=10 ----------------
    wr(A_TIMEOUT, 32'd10);
    wr(A_CTRL, 32'h3);
    wr(A_COUNT, 32'h0); m_acc = 0; m_drop = 0;
    present(int'($urandom_range(60, 1518)), 1'($urandom_range(0, 1))); m_acc++;
    check("to10_irq", 32'(irq), 32'd1);
    k = 0;
    while (!rx_cpu_ack && k < 50) begin step(); k++; end
    m_drop++;
    check("to10_latency", 32'(k), 32'd10);
    check("to10_irq_low", 32'(irq), 32'd0);
    handshake("to10");
    rd_check("to10_count", A_COUNT, 32'h0001_0001);

    // ---------------- release and timeout on the same edge ----------------
    wr(A_TIMEOUT, 32'd5);
    wr(A_COUNT, 32'h0); m_acc = 0; m_drop = 0;
    present(100, 1'b1); m_acc++;
    step(); step(); step(); step();
    check("tie_pre_ack", 32'(rx_cpu_ack), 32'd0);
    wr(A_CTRL, 32'h103);
    check("tie_ack", 32'(rx_cpu_ack), 32'd1);
    handshake("tie");
    rd_check("tie_count", A_COUNT, 32'h0000_0001);

    // ---------------- back-to-back frames ----------------
    wr(A_CTRL, 32'h1);
    wr(A_COUNT, 32'h0); m_acc = 0; m_drop = 0;
    present(1518, 1'b0); m_acc++;
    rd_check("b2b_status0", A_STATUS, 32'h8000_05EE);
    wr(A_CTRL, 32'h101);
    handshake("b2b0");
    present(60, 1'b1); m_acc++;
    check("b2b_ack_entry", 32'(rx_cpu_ack), 32'd0);
    check("b2b_irq1", 32'(irq), 32'd1);
    rd_check("b2b_status1", A_STATUS, 32'h8001_003C);
    wr(A_CTRL, 32'h101);
    handshake("b2b1");
    rd_check("b2b_count", A_COUNT, exp_count());

    // ---------------- TIMEOUT=0 behaves as 1 ----------------
    wr(A_TIMEOUT, 32'd0);
    wr(A_CTRL, 32'h3);
    present(200, 1'b0); m_acc++;
    check("to0_no_ack_yet", 32'(rx_cpu_ack), 32'd0);
    step(); m_drop++;
    check("to0_ack", 32'(rx_cpu_ack), 32'd1);
    handshake("to0");
    rd_check("to0_count", A_COUNT, exp_count());

    // ---------------- TIMEOUT lowered below running timer ----------------
    wr(A_TIMEOUT, 32'd100);
    present(300, 1'b1); m_acc++;
    for (int i = 0; i < 10; i++) step();
    wr(A_TIMEOUT, 32'd3);
    check("tolow_ack0", 32'(rx_cpu_ack), 32'd0);
    step(); m_drop++;
    check("tolow_ack1", 32'(rx_cpu_ack), 32'd1);
    handshake("tolow");
    rd_check("tolow_count", A_COUNT, exp_count());

    // ---------------- clear coinciding with capture ----------------
    wr(A_CTRL, 32'h1);
    rx_cpu_size = 11'd77; rx_cpu_buffer_sel = 1'b0; rx_cpu_ready = 1'b1;
    wr(A_COUNT, 32'h0); m_acc = 1; m_drop = 0;
    check("clrinc_irq", 32'(irq), 32'd1);
    wr(A_CTRL, 32'h101);
    handshake("clrinc");
    rd_check("clrinc_count", A_COUNT, 32'h0000_0001);

    // ---------------- RELEASE outside PENDING ----------------
    wr(A_CTRL, 32'h101);
    check("relidle_ack", 32'(rx_cpu_ack), 32'd0);
    rd_check("relidle_ctrl", A_CTRL, 32'h1);

    // ---------------- read/write same cycle ----------------
    wr(A_TIMEOUT, 32'd40);
    reg_addr = A_TIMEOUT; reg_wr_data = 32'd77; reg_wr = 1'b1; reg_rd = 1'b1;
    step();
    reg_wr = 1'b0; reg_rd = 1'b0;
    check("rw_old", reg_rd_data, 32'd40);
    rd_check("rw_new", A_TIMEOUT, 32'd77);

    // ---------------- randomized release/timeout frames ----------------
    wr(A_CTRL, 32'h3);
    wr(A_COUNT, 32'h0); m_acc = 0; m_drop = 0;
    for (int f = 0; f < 20; f++) begin
      T    = int'($urandom_range(1, 8));
      d    = int'($urandom_range(0, 10));
      size = int'($urandom_range(0, 2047));
      sel  = 1'($urandom_range(0, 1));
      wr(A_TIMEOUT, 32'(T));
      present(size, sel); m_acc++;
      // Release at timer value d wins iff the timer has not yet reached T-1 before it.
      L = (d + 1 <= T) ? d + 1 : T;
      if (d + 1 > T) m_drop++;
      k = 1;
      while (k <= 40) begin
        if (k == d + 1) wr(A_CTRL, 32'h103);
        else step();
        if (rx_cpu_ack) break;
        k++;
      end
      check("rnd_latency", 32'(k), 32'(L));
      rd_check("rnd_status", A_STATUS, exp_status(1'b0, sel, size));
      handshake("rnd");
      rd_check("rnd_count", A_COUNT, exp_count());
    end

    // ---------------- reset during ACK ----------------
    wr(A_CTRL, 32'h1);
    present(500, 1'b1);
    wr(A_CTRL, 32'h101);
    check("rstack_pre_ack", 32'(rx_cpu_ack), 32'd1);
    mac_rst = 1'b1;
    step();
    mac_rst = 1'b0;
    m_acc = 0; m_drop = 0;
    check("rstack_ack", 32'(rx_cpu_ack), 32'd0);
    check("rstack_irq", 32'(irq), 32'd0);
    check("rstack_rd", reg_rd_data, 32'd0);
    rx_cpu_ready = 1'b0;
    rd_check("rstack_status", A_STATUS, 32'd0);
    rd_check("rstack_ctrl", A_CTRL, 32'd0);
    rd_check("rstack_count", A_COUNT, exp_count());
    rd_check("rstack_timeout", A_TIMEOUT, 32'd12500000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
